// File: rtl/matmul_stream_ctrl.sv
// Stream sequencer around a combinational 4x4 matrix multiply: collects A and B one row per
// beat, fires the multiply into a result register, then drains the product one row per beat.
module matmul_stream_ctrl #(
   parameter int unsigned WIDTH_V    = 128,
   parameter int unsigned BITS_INDEX = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH_V/4-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH_V/4-1:0]   out_data,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned ROW_W = WIDTH_V / 4;
   localparam int unsigned DIM   = 4;

   typedef enum logic [1:0] {
      StLoadA,
      StLoadB,
      StCalc,
      StDrain
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           row_cnt_q, row_cnt_d;
   logic [WIDTH_V-1:0]   a_q, b_q, res_q;
   logic                 load_a, load_b, load_res;
   logic [WIDTH_V-1:0]   product;

   // Element (r, c) lives at flat index r*DIM + c, counted from the MSB end.
   function automatic logic [WIDTH_V-1:0] dot_product(input logic [WIDTH_V-1:0] a,
                                                      input logic [WIDTH_V-1:0] b);
      logic [WIDTH_V-1:0]    c;
      logic [BITS_INDEX-1:0] acc;
      c = '0;
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            acc = '0;
            for (int k = 0; k < DIM; k++) begin
               acc = acc + a[WIDTH_V-1-(i*DIM+k)*BITS_INDEX -: BITS_INDEX]
                         * b[WIDTH_V-1-(k*DIM+j)*BITS_INDEX -: BITS_INDEX];
            end
            c[WIDTH_V-1-(i*DIM+j)*BITS_INDEX -: BITS_INDEX] = acc;
         end
      end
      return c;
   endfunction

   assign product = dot_product(a_q, b_q);

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      done      = 1'b0;
      busy      = 1'b1;
      load_a    = 1'b0;
      load_b    = 1'b0;
      load_res  = 1'b0;

      unique case (state_q)
         StLoadA: begin
            in_ready = 1'b1;
            busy     = (row_cnt_q != 2'd0);
            if (in_valid) begin
               load_a    = 1'b1;
               row_cnt_d = row_cnt_q + 2'd1;
               if (row_cnt_q == 2'd3) begin
                  state_d = StLoadB;
               end
            end
         end
         StLoadB: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_b    = 1'b1;
               row_cnt_d = row_cnt_q + 2'd1;
               if (row_cnt_q == 2'd3) begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            load_res = 1'b1;
            state_d  = StDrain;
         end
         StDrain: begin
            out_valid = 1'b1;
            out_last  = (row_cnt_q == 2'd3);
            if (out_ready) begin
               row_cnt_d = row_cnt_q + 2'd1;
               if (row_cnt_q == 2'd3) begin
                  done    = 1'b1;
                  state_d = StLoadA;
               end
            end
         end
         default: begin
            state_d   = StLoadA;
            row_cnt_d = 2'd0;
         end
      endcase

      // Flush drops the job and any handshake in the same cycle but keeps the data registers.
      if (flush) begin
         state_d   = StLoadA;
         row_cnt_d = 2'd0;
         load_a    = 1'b0;
         load_b    = 1'b0;
         load_res  = 1'b0;
         done      = 1'b0;
      end

      if (rst) begin
         state_d   = StLoadA;
         row_cnt_d = 2'd0;
         load_a    = 1'b0;
         load_b    = 1'b0;
         load_res  = 1'b0;
         in_ready  = 1'b0;
         out_valid = 1'b0;
         out_last  = 1'b0;
         done      = 1'b0;
         busy      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StLoadA;
         row_cnt_q <= 2'd0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         for (int r = 0; r < DIM; r++) begin
            if (row_cnt_q == 2'(r)) begin
               if (load_a) begin
                  a_q[WIDTH_V-1-r*ROW_W -: ROW_W] <= in_data;
               end
               if (load_b) begin
                  b_q[WIDTH_V-1-r*ROW_W -: ROW_W] <= in_data;
               end
            end
         end
         if (load_res) begin
            res_q <= product;
         end
      end
   end

   always_comb begin
      out_data = res_q[WIDTH_V-1 -: ROW_W];
      for (int r = 1; r < DIM; r++) begin
         if (row_cnt_q == 2'(r)) begin
            out_data = res_q[WIDTH_V-1-r*ROW_W -: ROW_W];
         end
      end
   end

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Self-checking bench for matmul_stream_ctrl: a job-level model (beat count, pending product
// rows) is compared against the DUT every cycle, plus literal checks on directed jobs.
module tb_matmul_stream_ctrl;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   matmul_stream_ctrl #(
      .WIDTH_V    (128),
      .BITS_INDEX (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          asserts = 0;
   int          fails   = 0;

   // Model state
   bit          model_ok = 0;
   int          beats    = 0;
   bit          calc     = 0;
   logic [31:0] mrows[8];
   logic [31:0] pend[$];

   logic [31:0] got[$];
   int          hs_out_cnt = 0;
   logic [31:0] job_rows[8];
   int          ready_pct = 100;
   bit          hold_off  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int elem(input logic [31:0] row, input int c);
      logic [31:0] s;
      s = row >> (24 - 8 * c);
      return int'(s & 32'hFF);
   endfunction

   function automatic logic [31:0] prod_row(input int i);
      logic [31:0] r;
      int          s;
      r = '0;
      for (int j = 0; j < 4; j++) begin
         s = 0;
         for (int k = 0; k < 4; k++) s += elem(mrows[i], k) * elem(mrows[4 + k], j);
         r = r | (32'(s & 255) << (24 - 8 * j));
      end
      return r;
   endfunction

   // Compare at negedge, then advance the model to reflect the coming posedge.
   always @(negedge clk) begin
      bit exp_in_ready, exp_out_valid, exp_last, exp_done, exp_busy;
      exp_in_ready  = !rst && beats < 8;
      exp_out_valid = !rst && !calc && pend.size() > 0;
      exp_last      = exp_out_valid && pend.size() == 1;
      exp_done      = exp_last && out_ready && !flush;
      exp_busy      = !rst && (beats != 0 || pend.size() > 0);
      if (model_ok) begin
         chk("in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready});
         chk("out_valid", {31'b0, out_valid}, {31'b0, exp_out_valid});
         chk("done", {31'b0, done}, {31'b0, exp_done});
         chk("busy", {31'b0, busy}, {31'b0, exp_busy});
         if (exp_out_valid) begin
            chk("out_last", {31'b0, out_last}, {31'b0, exp_last});
            chk("out_data", out_data, pend[0]);
         end else begin
            chk("out_last_idle", {31'b0, out_last}, 32'd0);
         end
      end
      if (!rst && !flush && out_valid && out_ready) begin
         got.push_back(out_data);
         hs_out_cnt++;
      end
      if (rst || flush) begin
         beats = 0;
         calc  = 0;
         pend.delete();
      end else begin
         if (calc) begin
            calc = 0;
         end else if (exp_out_valid && out_ready) begin
            void'(pend.pop_front());
            if (pend.size() == 0) beats = 0;
         end
         if (exp_in_ready && in_valid) begin
            mrows[beats] = in_data;
            beats++;
            if (beats == 8) begin
               for (int i = 0; i < 4; i++) pend.push_back(prod_row(i));
               calc = 1;
            end
         end
      end
      if (rst) model_ok = 1;
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = hold_off ? 1'b0 : ($urandom_range(99) < ready_pct);
      end
   end

   // mode 0: back-to-back, 1: one bubble before every beat, 2: random bubbles
   task automatic send_rows(input int first, input int count, input int mode);
      bit hs;
      int t;
      @(posedge clk);
      #1;
      for (int r = first; r < first + count; r++) begin
         if (mode == 1 || (mode == 2 && $urandom_range(3) == 0)) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = job_rows[r];
         hs = 0;
         t  = 0;
         while (!hs) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!hs && t > 300) begin
               chk("in_handshake_timeout", 32'd0, 32'd1);
               hs = 1;
            end
         end
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_hs(input int target);
      int t;
      t = 0;
      while (hs_out_cnt < target) begin
         @(posedge clk);
         t++;
         if (t > 500) begin
            chk("out_handshake_timeout", hs_out_cnt, target);
            break;
         end
      end
   endtask

   task automatic load_case1();
      job_rows[0] = 32'h01000000;
      job_rows[1] = 32'h00010000;
      job_rows[2] = 32'h00000100;
      job_rows[3] = 32'h00000001;
      job_rows[4] = 32'h01020304;
      job_rows[5] = 32'h05060708;
      job_rows[6] = 32'h090A0B0C;
      job_rows[7] = 32'h0D0E0F10;
   endtask

   task automatic check_case1(input string tag);
      logic [31:0] exp_rows[4];
      exp_rows[0] = 32'h01020304;
      exp_rows[1] = 32'h05060708;
      exp_rows[2] = 32'h090A0B0C;
      exp_rows[3] = 32'h0D0E0F10;
      chk({tag, "_rows"}, got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) chk({tag, "_row"}, got[i], exp_rows[i]);
   endtask

   task automatic check_case2(input string tag);
      chk({tag, "_rows"}, got.size(), 4);
      for (int i = 0; i < got.size(); i++) chk({tag, "_row"}, got[i], 32'h04040404);
   endtask

   int base;

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

      // Identity times B
      load_case1();
      got.delete();
      base = hs_out_cnt;
      send_rows(0, 8, 0);
      wait_hs(base + 4);
      check_case1("ident");

      // All-FF operands
      for (int i = 0; i < 8; i++) job_rows[i] = 32'hFFFFFFFF;
      got.delete();
      base = hs_out_cnt;
      send_rows(0, 8, 0);
      wait_hs(base + 4);
      check_case2("allff");

      // Backpressure on row 1
      load_case1();
      got.delete();
      base = hs_out_cnt;
      send_rows(0, 8, 0);
      wait_hs(base + 1);
      hold_off = 1;
      repeat (3) @(posedge clk);
      hold_off = 0;
      wait_hs(base + 4);
      check_case1("stall");

      // Toggled in_valid
      got.delete();
      base = hs_out_cnt;
      send_rows(0, 8, 1);
      wait_hs(base + 4);
      check_case1("toggle");

      // Flush after product row 1, then a clean job
      got.delete();
      base = hs_out_cnt;
      send_rows(0, 8, 0);
      wait_hs(base + 2);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_rows", got.size(), 2);
      for (int i = 0; i < 8; i++) job_rows[i] = 32'hFFFFFFFF;
      got.delete();
      base = hs_out_cnt;
      send_rows(0, 8, 0);
      wait_hs(base + 4);
      check_case2("postflush");

      // Reset after B row 1, then a fresh job
      load_case1();
      send_rows(0, 6, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      got.delete();
      base = hs_out_cnt;
      send_rows(0, 8, 0);
      wait_hs(base + 4);
      check_case1("postrst");

      // Random jobs with random bubbles and backpressure
      ready_pct = 60;
      for (int j = 0; j < 20; j++) begin
         for (int i = 0; i < 8; i++) job_rows[i] = $urandom;
         base = hs_out_cnt;
         send_rows(0, 8, 2);
         if (j % 3 == 0) wait_hs(base + 4);
      end
      wait_hs(base + 4);
      repeat (5) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
